anton_neopixel_sequencer: RTL
=============================

# anton_neopixel_sequencer

Timing and sequencing stage that sits directly upstream of the NeoPixel stream encoder. It generates `state`, `pixelIndex`, `pixelBitIndex` and `bitPatternIndex` for the encoder. It walks the pixel buffer bit by bit in 8-tick bit slots, then inserts the latch/reset gap between frames. It also reports end-of-frame to the register block for one-shot versus looping operation.

## Interface
Parameters:
- `BUFFER_END`, `BUFFER_END_DEFAULT`: last valid byte index of the pixel buffer.
- `RESET_DELAY`, 320: cycles of forced-low latch gap (50 µs at 6.4 MHz).
- `BUFFER_BITS`, localparam `CLOG2(BUFFER_END+1)`: index width.
- `DELAY_BITS`, localparam `CLOG2(RESET_DELAY+1)`: gap counter width.

Ports:
- `clk6mhz` in 1: single clock, 6.4 MHz tick (8 ticks = 1.25 µs bit slot).
- `resetN` in 1: asynchronous, active-low reset.
- `regCtrlRun` in 1: enable streaming.
- `regCtrlLoop` in 1: 1 = restart after each frame, 0 = one frame then stop.
- `regCtrl32bit` in 1: 1 = 4 bytes per pixel, 0 = 1 byte per pixel.
- `regMax` in BUFFER_BITS: byte index of the last pixel to send.
- `state` out 1: `ENUM_STATE_RESET` or `ENUM_STATE_TRANSMIT`.
- `pixelIndex` out BUFFER_BITS: byte index of the current pixel.
- `pixelBitIndex` out 5: bit 0..23 within the pixel.
- `bitPatternIndex` out 3: tick 0..7 within the bit slot.
- `streamSyncOf` out 1: one-cycle pulse at end of frame.
- `regCtrlRunClr` out 1: one-cycle request to clear Run (one-shot mode only).

## Operation
- All outputs are registered.
- Reset values: `state`=RESET, all indices 0, gap counter 0, `streamSyncOf`=0, `regCtrlRunClr`=0.
- Effective max: `effMax` = min(`regMax`, `BUFFER_END`). In 32-bit mode, compare only `[BUFFER_BITS-1:2]`.
- RESET state:
  - Indices are held at 0.
  - If `regCtrlRun`=1, the gap counter increments each cycle. When it reaches `RESET_DELAY-1`, the counter clears and the state moves to TRANSMIT on the next edge.
  - If `regCtrlRun`=0, the gap counter is held at 0.
- TRANSMIT state:
  - `bitPatternIndex` increments every cycle and wraps 7→0.
  - On that wrap, `pixelBitIndex` increments and wraps 23→0.
  - On that wrap, `pixelIndex` advances by 4 in 32-bit mode (low 2 bits forced 00) or by 1 in 8-bit mode.
- End of frame: the cycle where `bitPatternIndex`=7, `pixelBitIndex`=23 and `pixelIndex` matches `effMax`. On the next edge:
  - `state` goes to RESET and all indices go to 0.
  - `streamSyncOf` pulses for 1 cycle.
  - If `regCtrlLoop`=0, `regCtrlRunClr` also pulses for 1 cycle.
- Run dropped mid-frame: on the next edge, `state` goes to RESET, indices and gap counter clear, and no `streamSyncOf` pulse is issued. When Run is reasserted, a full `RESET_DELAY` gap precedes transmission.
- Mode or `regMax` change mid-frame: the new value takes effect immediately. Behaviour is defined by the rules above with no special handling; firmware changes these only while Run=0.
- `pixelIndex` never exceeds `BUFFER_END`. If incrementing would pass `effMax`, the end-of-frame rule fires first.
- `resetN` asserted mid-operation: asynchronously returns all registers to their reset values.

## Timing
- Gap: exactly `RESET_DELAY` cycles with `state`=RESET after Run is seen high.
- Bit slot: 8 cycles. Pixel: 192 cycles.
- Frame of P pixels: P×192 cycles of TRANSMIT.
  - 8-bit mode: P = `effMax`+1.
  - 32-bit mode: P = `effMax[BUFFER_BITS-1:2]`+1.
- Looping: frame, gap, frame with no idle cycles between.
- `regCtrlRunClr` and `streamSyncOf` are asserted in the same cycle, the first RESET cycle. The register block clears Run on that edge, so the gap counter advances at most 1 count before Run reads 0.

## Test plan
- Reset + Run=1, Loop=1, 8-bit, `regMax`=2, `RESET_DELAY`=320 → 320 RESET cycles, then 576 TRANSMIT cycles. `pixelIndex` sequence is 0,1,2. `streamSyncOf` pulses once, then a 320-cycle gap, then the frame repeats.
- 32-bit, `regMax`=11 → `pixelIndex` is 0,4,8, each for 192 cycles. The frame ends after 576 cycles.
- Loop=0, 8-bit, `regMax`=0 → a single 192-cycle frame. `regCtrlRunClr` and `streamSyncOf` pulse together in the same cycle. With Run then driven 0, `state` stays RESET and all indices stay 0.
- Run dropped at `pixelIndex`=1, `pixelBitIndex`=10 → next edge `state`=RESET, indices 0, no sync pulse. Reasserting Run yields a full 320-cycle gap.
- `regMax`=`BUFFER_END`+5 → the frame ends at `pixelIndex`=`BUFFER_END`. `pixelIndex` never exceeds it.
- `resetN` pulsed low mid-TRANSMIT (not clock-aligned) → all outputs immediately return to their reset values.

Source files
------------

// File: rtl/anton_neopixel_sequencer.sv
// Bit/pixel/frame sequencer for the NeoPixel stream encoder: walks the buffer in
// 8-tick bit slots and inserts the forced-low latch gap between frames.
module anton_neopixel_sequencer #(
    parameter  int BUFFER_END  = 10,
    parameter  int RESET_DELAY = 320,
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1),
    localparam int DELAY_BITS  = $clog2(RESET_DELAY + 1)
) (
    input  logic                   clk6mhz,
    input  logic                   resetN,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLoop,
    input  logic                   regCtrl32bit,
    input  logic [BUFFER_BITS-1:0] regMax,
    output logic                   state,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [4:0]             pixelBitIndex,
    output logic [2:0]             bitPatternIndex,
    output logic                   streamSyncOf,
    output logic                   regCtrlRunClr
);

    typedef enum logic {
        ENUM_STATE_RESET    = 1'b0,
        ENUM_STATE_TRANSMIT = 1'b1
    } state_e;

    localparam logic [BUFFER_BITS-1:0] BUF_END_L = BUFFER_BITS'(BUFFER_END);
    localparam logic [DELAY_BITS-1:0]  GAP_LAST  = DELAY_BITS'(RESET_DELAY - 1);

    state_e                 state_q;
    logic [BUFFER_BITS-1:0] pixel_q;
    logic [4:0]             bit_q;
    logic [2:0]             pattern_q;
    logic [DELAY_BITS-1:0]  gap_q;
    logic                   sync_q;
    logic                   run_clr_q;

    logic [BUFFER_BITS-1:0] eff_max;
    logic [BUFFER_BITS-1:0] pixel_d;
    logic                   pixel_last;
    logic                   frame_end;

    // A ">=" compare (rather than equality) keeps pixelIndex bounded even if
    // regMax is lowered underneath a running frame.
    always_comb begin
        eff_max    = (regMax > BUF_END_L) ? BUF_END_L : regMax;
        pixel_last = regCtrl32bit ? (pixel_q[BUFFER_BITS-1:2] >= eff_max[BUFFER_BITS-1:2])
                                  : (pixel_q >= eff_max);
        frame_end  = (pattern_q == 3'd7) && (bit_q == 5'd23) && pixel_last;
        pixel_d    = regCtrl32bit ? ({pixel_q[BUFFER_BITS-1:2], 2'b00} + BUFFER_BITS'(4))
                                  : (pixel_q + BUFFER_BITS'(1));
    end

    always_ff @(posedge clk6mhz or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ENUM_STATE_RESET;
            pixel_q   <= '0;
            bit_q     <= '0;
            pattern_q <= '0;
            gap_q     <= '0;
            sync_q    <= 1'b0;
            run_clr_q <= 1'b0;
        end else begin
            sync_q    <= 1'b0;
            run_clr_q <= 1'b0;
            if (state_q == ENUM_STATE_RESET) begin
                pixel_q   <= '0;
                bit_q     <= '0;
                pattern_q <= '0;
                if (!regCtrlRun) begin
                    gap_q <= '0;
                end else if (gap_q == GAP_LAST) begin
                    gap_q   <= '0;
                    state_q <= ENUM_STATE_TRANSMIT;
                end else begin
                    gap_q <= gap_q + DELAY_BITS'(1);
                end
            end else if (!regCtrlRun || frame_end) begin
                // Aborting on Run low is silent; only a completed frame reports sync.
                state_q   <= ENUM_STATE_RESET;
                pixel_q   <= '0;
                bit_q     <= '0;
                pattern_q <= '0;
                gap_q     <= '0;
                sync_q    <= regCtrlRun;
                run_clr_q <= regCtrlRun && !regCtrlLoop;
            end else begin
                pattern_q <= pattern_q + 3'd1;
                if (pattern_q == 3'd7) begin
                    if (bit_q == 5'd23) begin
                        bit_q   <= '0;
                        pixel_q <= pixel_d;
                    end else begin
                        bit_q <= bit_q + 5'd1;
                    end
                end
            end
        end
    end

    assign state           = state_q;
    assign pixelIndex      = pixel_q;
    assign pixelBitIndex   = bit_q;
    assign bitPatternIndex = pattern_q;
    assign streamSyncOf    = sync_q;
    assign regCtrlRunClr   = run_clr_q;

endmodule
